// File: rtl/reg_hazard_scoreboard_pkg.sv
// Shared definitions for the register hazard scoreboard: register file
// geometry, the untracked PC register number and the per-register
// outstanding-write counter type.
package reg_hazard_scoreboard_pkg;

  localparam int NUM_REGS     = 16;
  localparam int ADDR_WIDTH   = $clog2(NUM_REGS);
  localparam int PC_REG_NUM   = 15;
  localparam int MAX_INFLIGHT = 3;
  localparam int CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1);
  localparam int NUM_SRC      = 3;

  typedef logic [CNT_WIDTH-1:0]  sb_count_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

  // The PC is written by branches through a separate path, so it is never
  // tracked as a hazard source or destination.
  function automatic logic is_pc(input reg_addr_t addr);
    return addr == ADDR_WIDTH'(PC_REG_NUM);
  endfunction

endpackage

// File: rtl/reg_hazard_scoreboard_counter.sv
// reg_pending_counter: outstanding-write counter for one architectural
// register. Applies +inc -dec each cycle; a release that would take the
// count below zero clamps it to zero and pulses underflow_o.
module reg_pending_counter
  import reg_hazard_scoreboard_pkg::*;
#(
  parameter int MAX_CNT = MAX_INFLIGHT
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       inc_i,
  input  logic [1:0] dec_i,
  output sb_count_t  count_o,
  output logic       nonzero_o,
  output logic       full_o,
  output logic       underflow_o
);

  sb_count_t            count_reg;
  sb_count_t            count_next;
  logic [CNT_WIDTH:0]   sum;
  logic [CNT_WIDTH:0]   dec_ext;

  // Net update: one spare bit so cnt+inc never wraps before the compare.
  always_comb begin
    sum         = {1'b0, count_reg} + (CNT_WIDTH + 1)'(inc_i);
    dec_ext     = (CNT_WIDTH + 1)'(dec_i);
    underflow_o = dec_ext > sum;
    count_next  = underflow_o ? '0 : sb_count_t'(sum - dec_ext);
  end

  // Count register, cleared asynchronously with the pipeline flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count_o   = count_reg;
  assign nonzero_o = count_reg != '0;
  assign full_o    = count_reg == sb_count_t'(MAX_CNT);

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// reg_hazard_scoreboard: tracks outstanding register writes between decode
// and execute issue, stalling decode on RAW hazards and on WAW when a
// destination already has the maximum number of writes in flight.
// Optional build macro SCOREBOARD_WB_BYPASS_EN: a source whose single
// pending write is retiring through writeback this cycle does not stall,
// because writeback forwards into decode.
module reg_hazard_scoreboard
  import reg_hazard_scoreboard_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          issue_valid_i,
  input  logic [NUM_SRC-1:0]            src_en_i,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] src_addr_i,
  input  logic                          dest_en_i,
  input  reg_addr_t                     dest_addr_i,
  input  logic                          wb_valid_i,
  input  reg_addr_t                     wb_addr_i,
  input  logic                          kill_valid_i,
  input  reg_addr_t                     kill_addr_i,
  output logic                          stall_o,
  output logic                          issue_ack_o,
  output logic [NUM_REGS-1:0]           pending_vec_o,
  output logic                          err_underflow_o
);

  sb_count_t           count [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [1:0]          dec_vec [NUM_REGS];
  logic [NUM_REGS-1:0] nonzero_vec;
  logic [NUM_REGS-1:0] full_vec;
  logic [NUM_REGS-1:0] underflow_vec;
  logic                raw_hazard;
  logic                waw_full;
  logic                err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam reg_addr_t ADDR = ADDR_WIDTH'(gi);
      logic wb_hit;
      logic kill_hit;

      if (gi == PC_REG_NUM) begin : g_pc
        // PC is untracked: its counter never moves.
        assign inc_vec[gi] = 1'b0;
        assign wb_hit      = 1'b0;
        assign kill_hit    = 1'b0;
      end else begin : g_gpr
        assign inc_vec[gi] = issue_ack_o & dest_en_i & (dest_addr_i == ADDR);
        assign wb_hit      = wb_valid_i & (wb_addr_i == ADDR);
        assign kill_hit    = kill_valid_i & (kill_addr_i == ADDR);
      end

      assign dec_vec[gi]       = {1'b0, wb_hit} + {1'b0, kill_hit};
      assign pending_vec_o[gi] = count[gi] != '0;

      reg_pending_counter #(
        .MAX_CNT (MAX_INFLIGHT)
      ) u_cnt (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .inc_i       (inc_vec[gi]),
        .dec_i       (dec_vec[gi]),
        .count_o     (count[gi]),
        .nonzero_o   (nonzero_vec[gi]),
        .full_o      (full_vec[gi]),
        .underflow_o (underflow_vec[gi])
      );
    end
  endgenerate

  // Hazard detection on the registered counts; the issuing instruction's own
  // increment is not visible here, so ADD r1,r1 only sees older writers.
  always_comb begin
    raw_hazard = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_en_i[k] && !is_pc(src_addr_i[k]) && nonzero_vec[src_addr_i[k]]) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (!(wb_valid_i && (wb_addr_i == src_addr_i[k]) &&
              (count[src_addr_i[k]] == sb_count_t'(1)))) begin
          raw_hazard = 1'b1;
        end
`else
        raw_hazard = 1'b1;
`endif
      end
    end
    waw_full = dest_en_i && !is_pc(dest_addr_i) && full_vec[dest_addr_i];
  end

  assign stall_o     = issue_valid_i & (raw_hazard | waw_full);
  assign issue_ack_o = issue_valid_i & ~stall_o;

  // Sticky underflow flag: any release against an empty counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_reg <= 1'b0;
    end else if (|underflow_vec) begin
      err_reg <= 1'b1;
    end
  end

  assign err_underflow_o = err_reg;

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Directed testbench for reg_hazard_scoreboard. Inputs change 1ns after the
// rising edge; outputs are checked 2ns after the edge.
module tb_reg_hazard_scoreboard;
  import reg_hazard_scoreboard_pkg::*;

  logic                               clk_i = 1'b0;
  logic                               rst_n_i;
  logic                               issue_valid_i;
  logic [NUM_SRC-1:0]                 src_en_i;
  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] src_addr_i;
  logic                               dest_en_i;
  reg_addr_t                          dest_addr_i;
  logic                               wb_valid_i;
  reg_addr_t                          wb_addr_i;
  logic                               kill_valid_i;
  reg_addr_t                          kill_addr_i;
  logic                               stall_o;
  logic                               issue_ack_o;
  logic [NUM_REGS-1:0]                pending_vec_o;
  logic                               err_underflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  reg_hazard_scoreboard dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .issue_valid_i   (issue_valid_i),
    .src_en_i        (src_en_i),
    .src_addr_i      (src_addr_i),
    .dest_en_i       (dest_en_i),
    .dest_addr_i     (dest_addr_i),
    .wb_valid_i      (wb_valid_i),
    .wb_addr_i       (wb_addr_i),
    .kill_valid_i    (kill_valid_i),
    .kill_addr_i     (kill_addr_i),
    .stall_o         (stall_o),
    .issue_ack_o     (issue_ack_o),
    .pending_vec_o   (pending_vec_o),
    .err_underflow_o (err_underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 1'b0;
    src_en_i      = '0;
    src_addr_i    = '0;
    dest_en_i     = 1'b0;
    dest_addr_i   = '0;
    wb_valid_i    = 1'b0;
    wb_addr_i     = '0;
    kill_valid_i  = 1'b0;
    kill_addr_i   = '0;
  endtask

  task automatic issue_dest(input reg_addr_t d);
    idle();
    issue_valid_i = 1'b1;
    dest_en_i     = 1'b1;
    dest_addr_i   = d;
  endtask

  task automatic issue_src(input int port, input reg_addr_t s);
    idle();
    issue_valid_i    = 1'b1;
    src_en_i[port]   = 1'b1;
    src_addr_i[port] = s;
  endtask

  initial begin
    idle();
    rst_n_i = 1'b0;

    // 1: reset held, issue and kill driven -> nothing recorded
    tick();
    settle();
    check("rst_ack_idle", 32'(issue_ack_o), 32'h0);
    issue_dest(4'd2);
    src_en_i[0]   = 1'b1;
    src_addr_i[0] = 4'd2;
    kill_valid_i  = 1'b1;
    kill_addr_i   = 4'd7;
    tick();
    tick();
    settle();
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_pending", 32'(pending_vec_o), 32'h0);
    check("rst_err", 32'(err_underflow_o), 32'h0);
    idle();
    rst_n_i = 1'b1;
    tick();
    settle();
    check("rst_pending_after", 32'(pending_vec_o), 32'h0);

    // 2: RAW on r2
    issue_dest(4'd2);
    settle();
    check("raw_dest_ack", 32'(issue_ack_o), 32'h1);
    tick();
    issue_src(0, 4'd2);
    settle();
    check("raw_pending", 32'(pending_vec_o), 32'h0004);
    check("raw_stall", 32'(stall_o), 32'h1);
    check("raw_ack", 32'(issue_ack_o), 32'h0);
    tick();
    wb_valid_i = 1'b1;
    wb_addr_i  = 4'd2;
    settle();
`ifdef SCOREBOARD_WB_BYPASS_EN
    check("raw_wb_same_cycle", 32'(stall_o), 32'h0);
`else
    check("raw_wb_same_cycle", 32'(stall_o), 32'h1);
`endif
    tick();
    wb_valid_i = 1'b0;
    settle();
    check("raw_after_wb_stall", 32'(stall_o), 32'h0);
    check("raw_after_wb_ack", 32'(issue_ack_o), 32'h1);
    check("raw_after_wb_pend", 32'(pending_vec_o), 32'h0);
    tick();

    // 3: WAW full on r4
    for (int i = 0; i < 3; i++) begin
      issue_dest(4'd4);
      settle();
      check("waw_fill_ack", 32'(issue_ack_o), 32'h1);
      tick();
    end
    issue_dest(4'd4);
    settle();
    check("waw_full_stall", 32'(stall_o), 32'h1);
    check("waw_full_ack", 32'(issue_ack_o), 32'h0);
    check("waw_full_pend", 32'(pending_vec_o), 32'h0010);
    tick();
    wb_valid_i = 1'b1;
    wb_addr_i  = 4'd4;
    settle();
    check("waw_wb_still_stall", 32'(stall_o), 32'h1);
    tick();
    wb_valid_i = 1'b0;
    settle();
    check("waw_after_wb_ack", 32'(issue_ack_o), 32'h1);
    tick();
    issue_src(2, 4'd4);
    settle();
    check("raw_port3_stall", 32'(stall_o), 32'h1);
    src_en_i = '0;
    settle();
    check("src_disabled_stall", 32'(stall_o), 32'h0);
    issue_valid_i = 1'b0;
    src_en_i[2]   = 1'b1;
    settle();
    check("no_issue_stall", 32'(stall_o), 32'h0);
    idle();
    wb_valid_i = 1'b1;
    wb_addr_i  = 4'd4;
    tick();
    tick();
    settle();
    check("waw_two_wb_pend", 32'(pending_vec_o), 32'h0010);
    tick();
    idle();
    settle();
    check("waw_drained_pend", 32'(pending_vec_o), 32'h0);
    check("waw_err", 32'(err_underflow_o), 32'h0);

    // 4: simultaneous issue/retire on r5
    issue_dest(4'd5);
    tick();
    issue_dest(4'd5);
    wb_valid_i = 1'b1;
    wb_addr_i  = 4'd5;
    settle();
    check("sim_issue_wb_ack", 32'(issue_ack_o), 32'h1);
    tick();
    settle();
    check("sim_net_zero_pend", 32'(pending_vec_o), 32'h0020);
    kill_valid_i = 1'b1;
    kill_addr_i  = 4'd5;
    tick();
    idle();
    settle();
    check("sim_wb_kill_pend", 32'(pending_vec_o), 32'h0);
    check("sim_wb_kill_err", 32'(err_underflow_o), 32'h0);

    // 6: PC untracked
    issue_dest(4'd15);
    settle();
    check("pc_dest_ack", 32'(issue_ack_o), 32'h1);
    tick();
    issue_src(1, 4'd15);
    dest_en_i   = 1'b1;
    dest_addr_i = 4'd15;
    settle();
    check("pc_src_stall", 32'(stall_o), 32'h0);
    check("pc_pending", 32'(pending_vec_o), 32'h0);
    idle();
    wb_valid_i   = 1'b1;
    wb_addr_i    = 4'd15;
    kill_valid_i = 1'b1;
    kill_addr_i  = 4'd15;
    tick();
    idle();
    settle();
    check("pc_release_err", 32'(err_underflow_o), 32'h0);

    // 5: underflow on r7
    kill_valid_i = 1'b1;
    kill_addr_i  = 4'd7;
    tick();
    idle();
    settle();
    check("uf_err_set", 32'(err_underflow_o), 32'h1);
    check("uf_pending", 32'(pending_vec_o), 32'h0);
    issue_src(0, 4'd7);
    settle();
    check("uf_no_stall", 32'(stall_o), 32'h0);
    idle();
    tick();
    tick();
    settle();
    check("uf_err_sticky", 32'(err_underflow_o), 32'h1);

    // Async reset mid-cycle discards pending state and error
    issue_dest(4'd3);
    tick();
    issue_src(0, 4'd3);
    settle();
    check("mid_pending", 32'(pending_vec_o), 32'h0008);
    check("mid_stall", 32'(stall_o), 32'h1);
    #1;
    rst_n_i = 1'b0;
    #1;
    check("mid_rst_pending", 32'(pending_vec_o), 32'h0);
    check("mid_rst_err", 32'(err_underflow_o), 32'h0);
    check("mid_rst_stall", 32'(stall_o), 32'h0);
    idle();
    tick();
    rst_n_i = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
